mpi_noc_bridge: RTL and testbench

- Multi-channel, parametrised credit-based (valid/yummy) bridge between a local tile's NoC ports and the per-cycle MPI exchange layer.
- Buffers outbound flits per channel and tracks remote credits. Queues inbound flits per channel and tracks local credits.
- Returns yummies in both directions, decoupling tile traffic from the MPI exchange cadence set by mpi_work_i.
- Sits between the tile and the DPI transport wrapper. It contains no DPI calls itself.

---
 rtl/metro_mpi_pkg.sv | 22 ++
 rtl/mpi_chan_fifo.sv | 75 +++++++
 rtl/mpi_noc_bridge.sv | 186 ++++++++++++++++++
 tb/tb_mpi_noc_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metro_mpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : metro_mpi_pkg
// Purpose  : Shared constants, flit type and a counter-width helper for the
//            MPI/NoC bridge and its per-channel FIFOs.
// Contents : NOC_NUM_CH, NOC_DATA_W, noc_flit_t, cnt_width()
// Revision : 1.0 - initial release
// ============================================================================
package metro_mpi_pkg;

  localparam int NOC_NUM_CH = 3;
  localparam int NOC_DATA_W = 64;

  typedef logic [NOC_DATA_W-1:0] noc_flit_t;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpi_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mpi_chan_fifo
// Purpose  : Synchronous single-clock FIFO for one bridge channel direction.
//            A push while full is accepted only if a pop happens in the same
//            cycle; otherwise the flit is dropped and overflow pulses.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, push_data - write request and data
//            pop             - read request (ignored when empty)
//            head            - oldest entry (undefined when empty)
//            empty, full     - occupancy flags
//            overflow        - one-cycle pulse on a dropped push
// Revision : 1.0 - initial release
// ============================================================================
module mpi_chan_fifo
  import metro_mpi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop & ~empty;
  // A same-cycle pop frees the slot the push needs, so full does not block it.
  assign w_do_push = push & (~full | w_do_pop);
  assign overflow  = push & ~w_do_push;
  assign head      = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed behind empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mpi_noc_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mpi_noc_bridge
// Purpose  : Multi-channel credit-based (valid/yummy) bridge between a tile's
//            NoC ports and the per-cycle MPI exchange layer. Each channel has
//            an outbound FIFO gated by remote credits, an inbound FIFO gated by
//            local credits, and a pending-yummy counter returned to the remote
//            one per exchange.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            mpi_work_i          - an MPI exchange happens this cycle
//            noc_valid_i/data_i  - tile -> bridge flits
//            noc_yummy_o         - bridge -> tile credit return (registered)
//            noc_valid_o/data_o  - bridge -> tile flits
//            noc_yummy_i         - tile -> bridge credit return
//            tx_valid_o/data_o   - flit to remote this exchange
//            tx_yummy_o          - credit to remote this exchange
//            rx_valid_i/data_i   - flit from remote
//            rx_yummy_i          - credit from remote
//            err_o               - sticky FIFO/credit overflow per channel
// Revision : 1.0 - initial release
// ============================================================================
module mpi_noc_bridge
  import metro_mpi_pkg::*;
#(
  parameter int NUM_CH         = NOC_NUM_CH,
  parameter int DATA_W         = NOC_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int REMOTE_CREDITS = 4,
  parameter int LOCAL_CREDITS  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mpi_work_i,
  input  logic [NUM_CH-1:0]        noc_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] noc_data_i,
  output logic [NUM_CH-1:0]        noc_yummy_o,
  output logic [NUM_CH-1:0]        noc_valid_o,
  output logic [NUM_CH*DATA_W-1:0] noc_data_o,
  input  logic [NUM_CH-1:0]        noc_yummy_i,
  output logic [NUM_CH-1:0]        tx_valid_o,
  output logic [NUM_CH*DATA_W-1:0] tx_data_o,
  output logic [NUM_CH-1:0]        tx_yummy_o,
  input  logic [NUM_CH-1:0]        rx_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] rx_data_i,
  input  logic [NUM_CH-1:0]        rx_yummy_i,
  output logic [NUM_CH-1:0]        err_o
);

  localparam int RCW = cnt_width(REMOTE_CREDITS);
  localparam int LCW = cnt_width(LOCAL_CREDITS);
  localparam int PW  = cnt_width(FIFO_DEPTH);

  localparam logic [RCW-1:0] RC_MAX   = RCW'(REMOTE_CREDITS);
  localparam logic [LCW-1:0] LC_MAX   = LCW'(LOCAL_CREDITS);
  localparam logic [PW-1:0]  PEND_MAX = PW'(FIFO_DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [DATA_W-1:0] w_out_head;
    logic [DATA_W-1:0] w_in_head;
    logic              w_out_empty;
    logic              w_out_full;
    logic              w_out_ovf;
    logic              w_in_empty;
    logic              w_in_full;
    logic              w_in_ovf;
    logic              w_unused_full;

    logic              w_tx_send;
    logic              w_tile_send;
    logic              w_yummy_send;
    logic              w_rx_push;
    logic              w_rcred_inc;
    logic              w_lcred_inc;
    logic              w_rcred_ovf;
    logic              w_lcred_ovf;

    logic [RCW-1:0]    r_rcred;
    logic [LCW-1:0]    r_lcred;
    logic [PW-1:0]     r_pend;
    logic              r_noc_yummy;
    logic              r_err;

    // Full flags are informational only; push acceptance is decided inside
    // the FIFO, which also reports drops through overflow.
    assign w_unused_full = &{1'b0, w_out_full, w_in_full};

    // All send strobes are held low while reset is asserted so nothing leaves
    // the bridge during the cycle that flushes the buffers.
    assign w_tx_send    = ~rst_i & mpi_work_i & ~w_out_empty & (r_rcred != '0);
    assign w_tile_send  = ~rst_i & ~w_in_empty & (r_lcred != '0);
    assign w_yummy_send = ~rst_i & mpi_work_i & (r_pend != '0);

    // rx_* only carries meaning on an exchange cycle.
    assign w_rx_push   = mpi_work_i & rx_valid_i[c];
    assign w_rcred_inc = mpi_work_i & rx_yummy_i[c];
    assign w_lcred_inc = noc_yummy_i[c];

    // A returned credit coinciding with a send is absorbed by the send, so
    // overflow is only possible when the counter would actually step up.
    assign w_rcred_ovf = w_rcred_inc & ~w_tx_send   & (r_rcred == RC_MAX);
    assign w_lcred_ovf = w_lcred_inc & ~w_tile_send & (r_lcred == LC_MAX);

    mpi_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_out_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (noc_valid_i[c]),
      .push_data (noc_data_i[c*DATA_W +: DATA_W]),
      .pop       (w_tx_send),
      .head      (w_out_head),
      .empty     (w_out_empty),
      .full      (w_out_full),
      .overflow  (w_out_ovf)
    );

    mpi_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_in_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (w_rx_push),
      .push_data (rx_data_i[c*DATA_W +: DATA_W]),
      .pop       (w_tile_send),
      .head      (w_in_head),
      .empty     (w_in_empty),
      .full      (w_in_full),
      .overflow  (w_in_ovf)
    );

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_rcred     <= RC_MAX;
        r_lcred     <= LC_MAX;
        r_pend      <= '0;
        r_noc_yummy <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        // Remote credits: consumed by tx sends, returned by rx yummies.
        if (w_rcred_inc && !w_tx_send) begin
          if (r_rcred != RC_MAX) r_rcred <= r_rcred + RCW'(1);
        end else if (w_tx_send && !w_rcred_inc) begin
          r_rcred <= r_rcred - RCW'(1);
        end

        // Local credits: consumed by tile sends, returned by tile yummies.
        if (w_lcred_inc && !w_tile_send) begin
          if (r_lcred != LC_MAX) r_lcred <= r_lcred + LCW'(1);
        end else if (w_tile_send && !w_lcred_inc) begin
          r_lcred <= r_lcred - LCW'(1);
        end

        // Every flit handed to the tile frees a remote-visible slot; the
        // yummy for it goes out on a later exchange, one per exchange.
        if (w_tile_send && !w_yummy_send) begin
          if (r_pend != PEND_MAX) r_pend <= r_pend + PW'(1);
        end else if (w_yummy_send && !w_tile_send) begin
          r_pend <= r_pend - PW'(1);
        end

        // Popping the out-FIFO frees a slot the tile may refill.
        r_noc_yummy <= w_tx_send;

        if (w_out_ovf || w_in_ovf || w_rcred_ovf || w_lcred_ovf) begin
          r_err <= 1'b1;
        end
      end
    end

    assign tx_valid_o[c]                   = w_tx_send;
    assign tx_data_o[c*DATA_W +: DATA_W]   = w_tx_send ? w_out_head : '0;
    assign tx_yummy_o[c]                   = w_yummy_send;
    assign noc_valid_o[c]                  = w_tile_send;
    assign noc_data_o[c*DATA_W +: DATA_W]  = w_tile_send ? w_in_head : '0;
    // Registered outputs are masked while reset is held so the bridge is
    // quiet from the first reset cycle, not only after the flush edge.
    assign noc_yummy_o[c]                  = r_noc_yummy & ~rst_i;
    assign err_o[c]                        = r_err & ~rst_i;

  end

endmodule
`default_nettype wire

// File: tb/tb_mpi_noc_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpi_noc_bridge
// Purpose  : Self-checking bench for mpi_noc_bridge. A queue-based channel
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpi_noc_bridge;
  import metro_mpi_pkg::*;

  localparam int NCH   = 3;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int RC    = 4;
  localparam int LC    = 4;
  localparam int VW    = NCH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          work;
  logic [NCH-1:0] noc_valid_i, noc_yummy_i, rx_valid, rx_yummy;
  logic [VW-1:0]  noc_data_i, rx_data;
  logic [NCH-1:0] noc_yummy_o, noc_valid_o, tx_valid, tx_yummy, err;
  logic [VW-1:0]  noc_data_o, tx_data;

  always #5 clk = ~clk;

  mpi_noc_bridge #(
    .NUM_CH         (NCH),
    .DATA_W         (DW),
    .FIFO_DEPTH     (DEPTH),
    .REMOTE_CREDITS (RC),
    .LOCAL_CREDITS  (LC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mpi_work_i  (work),
    .noc_valid_i (noc_valid_i),
    .noc_data_i  (noc_data_i),
    .noc_yummy_o (noc_yummy_o),
    .noc_valid_o (noc_valid_o),
    .noc_data_o  (noc_data_o),
    .noc_yummy_i (noc_yummy_i),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_yummy_o  (tx_yummy),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_yummy_i  (rx_yummy),
    .err_o       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  noc_flit_t m_outq [NCH][$];
  noc_flit_t m_inq  [NCH][$];
  int        m_rcred [NCH];
  int        m_lcred [NCH];
  int        m_pend  [NCH];
  bit        m_err   [NCH];
  bit        m_yum   [NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_outq[c].delete();
        m_inq[c].delete();
        m_rcred[c] = RC;
        m_lcred[c] = LC;
        m_pend[c]  = 0;
        m_err[c]   = 1'b0;
        m_yum[c]   = 1'b0;
      end else begin
        bit tx, nv, ty;
        tx = work && (m_outq[c].size() > 0) && (m_rcred[c] > 0);
        nv = (m_inq[c].size() > 0) && (m_lcred[c] > 0);
        ty = work && (m_pend[c] > 0);
        // outbound
        if (tx) void'(m_outq[c].pop_front());
        if (noc_valid_i[c]) begin
          if (m_outq[c].size() < DEPTH) m_outq[c].push_back(noc_data_i[c*DW +: DW]);
          else m_err[c] = 1'b1;
        end
        m_yum[c] = tx;
        m_rcred[c] = m_rcred[c] + ((work && rx_yummy[c]) ? 1 : 0) - (tx ? 1 : 0);
        if (m_rcred[c] > RC) begin m_rcred[c] = RC; m_err[c] = 1'b1; end
        // inbound
        if (nv) void'(m_inq[c].pop_front());
        if (work && rx_valid[c]) begin
          if (m_inq[c].size() < DEPTH) m_inq[c].push_back(rx_data[c*DW +: DW]);
          else m_err[c] = 1'b1;
        end
        m_lcred[c] = m_lcred[c] + (noc_yummy_i[c] ? 1 : 0) - (nv ? 1 : 0);
        if (m_lcred[c] > LC) begin m_lcred[c] = LC; m_err[c] = 1'b1; end
        m_pend[c] = m_pend[c] + (nv ? 1 : 0) - (ty ? 1 : 0);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NCH-1:0] e_txv, e_nv, e_ty, e_ny, e_err;
    logic [VW-1:0]  e_txd, e_nd;
    e_txv = '0; e_nv = '0; e_ty = '0; e_ny = '0; e_err = '0;
    e_txd = '0; e_nd = '0;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (work && m_outq[c].size() > 0 && m_rcred[c] > 0) begin
          e_txv[c] = 1'b1;
          e_txd[c*DW +: DW] = m_outq[c][0];
        end
        if (m_inq[c].size() > 0 && m_lcred[c] > 0) begin
          e_nv[c] = 1'b1;
          e_nd[c*DW +: DW] = m_inq[c][0];
        end
        e_ty[c]  = work && (m_pend[c] > 0);
        e_ny[c]  = m_yum[c];
        e_err[c] = m_err[c];
      end
    end
    check("m_tx_valid",  VW'(tx_valid),    VW'(e_txv));
    check("m_tx_data",   tx_data,          e_txd);
    check("m_noc_valid", VW'(noc_valid_o), VW'(e_nv));
    check("m_noc_data",  noc_data_o,       e_nd);
    check("m_tx_yummy",  VW'(tx_yummy),    VW'(e_ty));
    check("m_noc_yummy", VW'(noc_yummy_o), VW'(e_ny));
    check("m_err",       VW'(err),         VW'(e_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    work = 1'b0; noc_valid_i = '0; noc_yummy_i = '0; rx_valid = '0; rx_yummy = '0;
    noc_data_i = '0; rx_data = '0;
    repeat (n) nxt();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int c);
    return v[c*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1; work = 1'b0;
    noc_valid_i = '0; noc_yummy_i = '0; rx_valid = '0; rx_yummy = '0;
    noc_data_i = '0; rx_data = '0;

    // ---- reset and idle ----
    neg();
    check("rst_outs", VW'({tx_valid, noc_valid_o, tx_yummy, noc_yummy_o, err}), '0);
    do_reset(2);
    neg();
    check("idle_outs", VW'({tx_valid, noc_valid_o, tx_yummy, noc_yummy_o, err}), '0);
    nxt();

    // ---- outbound credits on ch0 ----
    work = 1'b1;
    for (int k = 0; k < 6; k++) begin
      noc_valid_i = 3'b001;
      noc_data_i[0 +: DW] = 64'hA0 + 64'(k);
      neg();
      if (k >= 1 && k <= 4) begin
        check("out_send_v", VW'(tx_valid[0]), 1);
        check("out_send_d", VW'(lane(tx_data, 0)), VW'(64'hA0 + 64'(k - 1)));
      end
      if (k == 2) check("out_yummy", VW'(noc_yummy_o[0]), 1);
      if (k == 5) check("out_stall", VW'(tx_valid[0]), 0);
      nxt();
    end
    noc_valid_i = '0;
    repeat (2) begin
      neg();
      check("out_stall2", VW'(tx_valid[0]), 0);
      nxt();
    end
    rx_yummy = 3'b001;
    neg();
    check("credit_same_cyc", VW'(tx_valid[0]), 0);
    nxt();
    rx_yummy = '0;
    neg();
    check("release_v", VW'(tx_valid[0]), 1);
    check("release_d", VW'(lane(tx_data, 0)), VW'(64'hA4));
    nxt();
    neg();
    check("release_once", VW'(tx_valid[0]), 0);
    nxt();
    work = 1'b0;
    nxt();

    // ---- inbound credits on ch1 ----
    do_reset(1);
    work = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rx_valid = (k <= 4) ? 3'b010 : 3'b000;
      rx_data[DW +: DW] = 64'hB0 + 64'(k);
      neg();
      if (k >= 1 && k <= 4) begin
        check("in_deliver_v", VW'(noc_valid_o[1]), 1);
        check("in_deliver_d", VW'(lane(noc_data_o, 1)), VW'(64'hB0 + 64'(k - 1)));
      end
      if (k == 2 || k == 5) check("in_txyummy_on", VW'(tx_yummy[1]), 1);
      if (k == 6) begin
        check("in_txyummy_off", VW'(tx_yummy[1]), 0);
        check("in_5th_held", VW'(noc_valid_o[1]), 0);
      end
      nxt();
    end
    rx_valid = '0;
    noc_yummy_i = 3'b010;
    neg();
    check("in_yummy_same", VW'(noc_valid_o[1]), 0);
    nxt();
    noc_yummy_i = '0;
    neg();
    check("in_5th_v", VW'(noc_valid_o[1]), 1);
    check("in_5th_d", VW'(lane(noc_data_o, 1)), VW'(64'hB4));
    repeat (3) nxt();

    // ---- channel independence ch0 / ch2 ----
    do_reset(1);
    work = 1'b1;
    for (int k = 0; k < 6; k++) begin
      noc_valid_i = 3'b101;
      noc_data_i[0 +: DW]  = 64'hC0 + 64'(k);
      noc_data_i[2*DW +: DW] = 64'hD0 + 64'(k);
      neg();
      if (k == 1) begin
        check("ind_both", VW'(tx_valid), VW'(3'b101));
        check("ind_d2", VW'(lane(tx_data, 2)), VW'(64'hD0));
      end
      nxt();
    end
    noc_valid_i = '0;
    rx_yummy = 3'b001;
    nxt();
    rx_yummy = '0;
    neg();
    check("ind_ch0_only", VW'(tx_valid), VW'(3'b001));
    check("ind_ch0_d", VW'(lane(tx_data, 0)), VW'(64'hC4));
    repeat (2) nxt();

    // ---- overflow ----
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      noc_valid_i = 3'b001;
      noc_data_i[0 +: DW] = 64'hE0 + 64'(k);
      neg();
      if (k == 4) check("ovf_before", VW'(err), 0);
      nxt();
    end
    noc_valid_i = '0;
    neg();
    check("ovf_fifo", VW'(err), VW'(3'b001));
    nxt();
    work = 1'b1;
    rx_yummy = 3'b010;
    nxt();
    rx_yummy = '0;
    neg();
    check("ovf_rcred", VW'(err), VW'(3'b011));
    repeat (5) nxt();
    noc_yummy_i = 3'b100;
    nxt();
    noc_yummy_i = '0;
    repeat (3) nxt();
    neg();
    check("ovf_sticky", VW'(err), VW'(3'b111));
    nxt();
    // ch1 remote credits must still be 4 after the saturated return
    for (int k = 0; k < 6; k++) begin
      noc_valid_i = 3'b010;
      noc_data_i[DW +: DW] = 64'hF0 + 64'(k);
      neg();
      if (k == 5) check("rcred_sat", VW'(tx_valid[1]), 0);
      nxt();
    end
    noc_valid_i = '0;
    work = 1'b0;
    nxt();

    // ---- reset mid-stream ----
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      noc_valid_i = 3'b001;
      noc_data_i[0 +: DW] = 64'h90 + 64'(k);
      nxt();
    end
    noc_valid_i = '0;
    rst = 1'b1;
    work = 1'b1;
    neg();
    check("midrst_quiet", VW'({tx_valid, noc_yummy_o, err}), '0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      neg();
      check("midrst_flushed", VW'({tx_valid, noc_yummy_o}), '0);
      nxt();
    end
    work = 1'b0;
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
